// File: rtl/prog_loader.sv
// Boot loader: assembles little-endian words from a byte stream and writes them
// sequentially into IMEM or DMEM through the CPU external ports, then gates CPU run.
module prog_loader #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] imem_addr,
  output logic        imem_wen,
  output logic        imem_ren,
  output logic [31:0] imem_wdata,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic        dmem_ren,
  output logic [31:0] dmem_wdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        load_done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, WRITE} state_e;

  state_e      state_q, state_d;
  logic        tgt_q, tgt_d;          // 1 selects DMEM
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
  logic        cpu_en_q, cpu_en_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic        fire, in_range, last, wr;
  logic [31:0] depth;

  assign fire     = in_valid && in_ready;
  assign depth    = tgt_q ? 32'(DMEM_WORDS) : 32'(IMEM_WORDS);
  assign in_range = {16'd0, idx_q} < depth;
  assign last     = ({1'b0, idx_q} + 17'd1) == {1'b0, cnt_q};
  assign wr       = (state_q == WRITE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      tgt_q    <= 1'b0;
      cnt_q    <= 16'd0;
      idx_q    <= 16'd0;
      bcnt_q   <= 2'd0;
      cpu_en_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      cpu_en_q <= cpu_en_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // Word assembly register; its contents only reach the ports during WRITE.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    cpu_en_d = cpu_en_q;
    err_d    = err_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          case (in_data)
            8'h49, 8'h44: begin
              tgt_d    = (in_data == 8'h44);
              state_d  = HDR;
              cpu_en_d = 1'b0;
              err_d    = 1'b0;
              idx_d    = 16'd0;
              bcnt_d   = 2'd0;
            end
            8'h47:   cpu_en_d = 1'b1;
            8'h48:   cpu_en_d = 1'b0;
            default: err_d    = 1'b1;
          endcase
        end
      end
      HDR: begin
        if (fire) begin
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: cnt_d[7:0]  = in_data;
            2'd1: cnt_d[15:8] = in_data;
            default: begin
              bcnt_d = 2'd0;
              if (cnt_q == 16'd0) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = DATA;
              end
            end
          endcase
        end
      end
      DATA: begin
        if (fire) begin
          // Shift right so the first byte lands in [7:0] after four bytes.
          word_d = {in_data, word_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d = idx_q + 16'd1;
        if (!in_range) err_d = 1'b1;
        state_d = last ? IDLE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = !wr;
  assign busy       = (state_q != IDLE);
  assign load_done  = done_q | (wr && last);
  assign cpu_enable = cpu_en_q;
  assign err        = err_q;

  assign imem_ren   = 1'b0;
  assign dmem_ren   = 1'b0;
  assign imem_wen   = wr && !tgt_q && in_range;
  assign dmem_wen   = wr &&  tgt_q && in_range;
  assign imem_addr  = (wr && !tgt_q) ? {14'd0, idx_q, 2'b00} : 32'd0;
  assign dmem_addr  = (wr &&  tgt_q) ? {14'd0, idx_q, 2'b00} : 32'd0;
  assign imem_wdata = (wr && !tgt_q) ? word_q : 32'd0;
  assign dmem_wdata = (wr &&  tgt_q) ? word_q : 32'd0;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed command sequences with random data words and
// random valid gaps, compared against a word-list reference of expected writes.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
  logic        imem_wen, imem_ren, dmem_wen, dmem_ren;
  logic        cpu_enable, busy, load_done, err;

  prog_loader #(.IMEM_WORDS(512), .DMEM_WORDS(1024)) dut (
    .clk(clk), .arst_n(arst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren), .dmem_wdata(dmem_wdata),
    .cpu_enable(cpu_enable), .busy(busy), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        t;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         act_q[$];
  wr_t         exp_q[$];
  logic [31:0] pend[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          rdy_lo = 0;
  int          viol = 0;
  logic        done_wen = 1'b0;
  logic        exp_err;

  // Observe the DUT mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (arst_n) begin
      if (imem_wen) act_q.push_back({1'b0, imem_addr, imem_wdata});
      if (dmem_wen) act_q.push_back({1'b1, dmem_addr, dmem_wdata});
      if (load_done) begin
        done_cnt <= done_cnt + 1;
        done_wen <= imem_wen | dmem_wen;
      end
      if (!in_ready) rdy_lo <= rdy_lo + 1;
      if ((!in_ready && !busy) || imem_ren || dmem_ren || (imem_wen && dmem_wen) ||
          (imem_wen && (dmem_addr != 32'd0 || dmem_wdata != 32'd0)) ||
          (dmem_wen && (imem_addr != 32'd0 || imem_wdata != 32'd0)))
        viol <= viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit rnd);
    int g = 0;
    if (rnd) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Reference: word i of a block lands at byte address 4*i of the target when i < depth.
  task automatic load(input bit t, input int count, input bit rnd, input string tag);
    logic [15:0] c;
    logic [31:0] w;
    int          depth, r0, d0;
    c = 16'(count);
    depth = t ? 1024 : 512;
    r0 = rdy_lo;
    d0 = done_cnt;
    exp_err = 1'b0;
    send(t ? 8'h44 : 8'h49, rnd);
    chk({tag, "_cpu_en_clr"}, 65'(cpu_enable), 65'(0));
    chk({tag, "_err_clr"}, 65'(err), 65'(0));
    send(c[7:0], rnd);
    send(c[15:8], rnd);
    send(8'($urandom), rnd);
    for (int i = 0; i < count; i++) begin
      w = (pend.size() > 0) ? pend.pop_front() : $urandom;
      for (int k = 0; k < 4; k++) send(w[8*k +: 8], rnd);
      if (i < depth) exp_q.push_back({t, 32'(i * 4), w});
      else exp_err = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_nwrites"}, 65'(act_q.size()), 65'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_write"}, (i < act_q.size()) ? act_q[i] : 65'd0, exp_q[i]);
    chk({tag, "_done"}, 65'(done_cnt - d0), 65'(1));
    chk({tag, "_rdy_low"}, 65'(rdy_lo - r0), 65'(count));
    chk({tag, "_err"}, 65'(err), 65'(exp_err));
    chk({tag, "_busy"}, 65'(busy), 65'(0));
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 65'(busy), 65'(0));
    chk("rst_imem", {1'b0, imem_addr, imem_wdata}, 65'd0);
    chk("rst_dmem", {1'b0, dmem_addr, dmem_wdata}, 65'd0);
    chk("rst_wen_ren", 65'({imem_wen, imem_ren, dmem_wen, dmem_ren}), 65'(0));
    chk("rst_flags", 65'({cpu_enable, err, load_done}), 65'(0));
    arst_n = 1'b1;
    #1;
    chk("rst_in_ready", 65'(in_ready), 65'(1));
    @(posedge clk); #1;

    // Directed IMEM load with fixed words.
    pend.push_back(32'h2000_0001);
    pend.push_back(32'h0102_0304);
    load(1'b0, 2, 1'b0, "imem2");
    chk("imem2_done_on_wen", 65'(done_wen), 65'(1));

    // DMEM single word, then run control.
    pend.push_back(32'hDEAD_BEEF);
    load(1'b1, 1, 1'b0, "dmem1");
    send(8'h47, 1'b0);
    chk("go_enable", 65'(cpu_enable), 65'(1));
    send(8'h47, 1'b0);
    chk("go_again", 65'(cpu_enable), 65'(1));
    send(8'h48, 1'b0);
    chk("halt", 65'(cpu_enable), 65'(0));
    send(8'h47, 1'b0);
    chk("go_enable2", 65'(cpu_enable), 65'(1));
    load(1'b0, 0, 1'b0, "i_hdr_drops_run");

    // Bad command, then zero-count DMEM block clears it.
    send(8'h55, 1'b0);
    chk("bad_cmd_err", 65'(err), 65'(1));
    chk("bad_cmd_idle", 65'(busy), 65'(0));
    load(1'b1, 0, 1'b0, "dzero");
    chk("dzero_no_wen", 65'(done_wen), 65'(0));

    // Random valid gaps with random words.
    load(1'b0, 3, 1'b1, "hs_imem");
    load(1'b1, 3, 1'b1, "hs_dmem");

    // One word past IMEM depth.
    load(1'b0, 513, 1'b0, "ovf");

    // Reset in the middle of a word.
    send(8'h49, 1'b0);
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    chk("mid_busy", 65'(busy), 65'(1));
    arst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 65'(busy), 65'(0));
    chk("mid_rst_ready", 65'(in_ready), 65'(1));
    chk("mid_rst_imem", {1'b0, imem_addr, imem_wdata}, 65'd0);
    chk("mid_rst_flags", 65'({imem_wen, dmem_wen, load_done, err, cpu_enable}), 65'(0));
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_nowrite", 65'(act_q.size()), 65'(0));
    pend.push_back(32'hCAFE_F00D);
    load(1'b0, 1, 1'b0, "reload");

    chk("protocol_viol", 65'(viol), 65'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time loader that sits directly upstream of the CPU's external memory ports and its run enable. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words sequentially into instruction memory or data memory through the CPU's `*_ext` write ports. On command, it raises the CPU `enable` level that starts execution.

## Interface
Parameters:
- `IMEM_WORDS`, default 512: instruction memory depth in words (9-bit word address).
- `DMEM_WORDS`, default 1024: data memory depth in words (10-bit word address).

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `arst_n`, input, 1: asynchronous active-low reset.
- `in_data`, input, 8: stream byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: the loader can accept a byte; a byte transfers when `in_valid && in_ready` at a rising edge.
- `imem_addr`, output, 32: byte address to instruction memory `addr_ext`.
- `imem_wen`, output, 1: write strobe to `wen_ext`.
- `imem_ren`, output, 1: constant 0; drives `ren_ext`.
- `imem_wdata`, output, 32: word to `wdata_ext`.
- `dmem_addr`, `dmem_wen`, `dmem_ren`, `dmem_wdata`: same meanings, toward the `*_ext_2` ports.
- `cpu_enable`, output, 1: run level to the CPU `enable` input.
- `busy`, output, 1: high in any state other than IDLE.
- `load_done`, output, 1: one-cycle pulse when a load block completes.
- `err`, output, 1: sticky error flag; cleared only by reset or by a new `I`/`D` header.

## Operation
- States are IDLE, HDR, DATA, WRITE.
- **IDLE** consumes one command byte:
  - 0x49 `I`: target is IMEM; go to HDR.
  - 0x44 `D`: target is DMEM; go to HDR.
  - 0x47 `G`: set `cpu_enable` to 1; stay in IDLE.
  - 0x48 `H`: clear `cpu_enable` to 0; stay in IDLE.
  - Any other byte: set `err`; stay in IDLE.
- **Entering HDR** from `I` or `D`:
  - Clear `cpu_enable` (no writes while the CPU runs).
  - Clear `err`.
  - Reset the word index to 0.
- **HDR** consumes 3 bytes:
  - Byte 1 is count[7:0]; byte 2 is count[15:8]; byte 3 is reserved and ignored.
  - If count == 0: pulse `load_done` and return to IDLE.
  - Otherwise go to DATA.
- **DATA** consumes 4 bytes into a shift register, little-endian (first byte is bits [7:0]). After the 4th byte, go to WRITE.
- **WRITE** lasts exactly one cycle:
  - `in_ready` = 0.
  - Assert the selected `*_wen` if word index < depth of the target; otherwise write nothing and set `err`.
  - `*_addr` = index × 4 (byte address); `*_wdata` = assembled word.
  - Then increment the index.
  - If index + 1 == count: pulse `load_done` and go to IDLE. Otherwise go to DATA.
- Words past the target depth are still consumed from the stream, so framing stays aligned.
- The index and count are 16 bits, with no wrap: the maximum count is 65535.
- Only the selected target's `wen` ever asserts. The other target's address and data outputs hold 0.
- `in_ready` = 1 in IDLE, HDR and DATA.

## Timing
- **Reset values** (asynchronous, on `arst_n` low):
  - State = IDLE.
  - All addr, wdata, wen, ren outputs = 0.
  - `cpu_enable` = 0, `err` = 0, `load_done` = 0.
  - `in_ready` = 1 immediately after release.
- **Reset mid-operation:** a partial word, the count and the index are discarded, and no write strobe is produced.
- **Write latency:**
  - The 4th data byte is accepted at edge N.
  - `wen`, `addr` and `wdata` are valid during cycle N→N+1 and sampled by memory at edge N+1.
  - `wen` is low again after N+1.
- **Throughput:** one word per 5 cycles at full `in_valid`.
- **`load_done`:** high for exactly one cycle, coincident with the last WRITE cycle. For count == 0, it is the cycle after the 3rd header byte.
- **`cpu_enable`:**
  - Rises on the edge after `G` is accepted.
  - Falls on the edge after `H`, `I` or `D` is accepted.
  - A repeated `G` while already running has no effect.
- **Stalls:** `in_valid` low in any state stalls that state indefinitely without losing collected bytes.

## Test plan
- **IMEM load:** reset, send `I`,0x02,0x00,0x00, then 0x01,0x00,0x00,0x20 and 0x04,0x03,0x02,0x01.
  - IMEM writes of 0x20000001 @ addr 0 and 0x01020304 @ addr 4.
  - Exactly 2 `imem_wen` pulses, `load_done` on the second, `dmem_wen` never asserts.
- **DMEM load then run:** send `D`, count 1, word 0xDEADBEEF, then `G`.
  - `dmem_wen` pulse with addr 0 and 0xDEADBEEF.
  - `cpu_enable` = 1 the cycle after `G`.
  - A subsequent `I` header drops `cpu_enable` to 0.
- **Overflow:** `I` with count 513.
  - 512 writes (last at addr 2044); the 513th word is consumed with no `wen`.
  - `err` = 1, `load_done` pulses, `busy` returns to 0.
- **Bad command and zero count:**
  - Byte 0x55 in IDLE gives `err` = 1, stays in IDLE.
  - `D`,0x00,0x00,0x00 gives `err` = 0 and `load_done` with no writes.
- **Handshake:**
  - `in_valid` toggled randomly during a 3-word load: identical writes.
  - `in_ready` = 0 only in WRITE cycles.
- **Reset mid-word:** assert `arst_n` low after 2 of 4 data bytes.
  - Outputs go to 0 asynchronously, with no write.
  - After release, a fresh `I` count-1 load writes to addr 0.
